// File: rtl/jedro_1_trap_ctrl.sv
// jedro_1_trap_ctrl
//   Trap sequencer for the jedro_1 core. Arbitrates synchronous exceptions,
//   machine interrupts (MEI/MSI/MTI), MRET and WFI, owns the machine trap
//   CSRs and redirects fetch through a jump/ack handshake.
//
// Ports
//   clk_i, rstn_i            clock, asynchronous active-low reset
//   exc_*                    exception request, cause, faulting PC, trap value
//   mret_i, wfi_i, wfi_pc_i  retiring MRET / WFI (and the WFI's PC)
//   next_pc_i/_valid_i       precise PC of next instruction (interrupt mepc)
//   irq_msip/mtip/meip_i     level interrupt pending lines
//   csr_we/addr/wdata_i      software CSR write port (value already resolved)
//   jump_o/jump_addr_o       redirect request to fetch, held until jump_ack_i
//   busy_o, sleep_o          pipeline stall, WFI sleep indication
//   m*_o                     CSR read values
module jedro_1_trap_ctrl #(
   parameter logic [31:0] MTVEC_RESET = 32'h0040_0000,
   parameter bit          VECTORED_EN = 1'b1
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        exc_valid_i,
   input  logic [3:0]  exc_cause_i,
   input  logic [31:0] exc_pc_i,
   input  logic [31:0] exc_tval_i,
   input  logic        mret_i,
   input  logic        wfi_i,
   input  logic [31:0] wfi_pc_i,
   input  logic [31:0] next_pc_i,
   input  logic        next_pc_valid_i,
   input  logic        irq_msip_i,
   input  logic        irq_mtip_i,
   input  logic        irq_meip_i,
   input  logic        csr_we_i,
   input  logic [11:0] csr_addr_i,
   input  logic [31:0] csr_wdata_i,
   output logic        jump_o,
   output logic [31:0] jump_addr_o,
   input  logic        jump_ack_i,
   output logic        busy_o,
   output logic        sleep_o,
   output logic [31:0] mstatus_o,
   output logic [31:0] mie_o,
   output logic [31:0] mip_o,
   output logic [31:0] mtvec_o,
   output logic [31:0] mepc_o,
   output logic [31:0] mcause_o,
   output logic [31:0] mtval_o
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_JUMP  = 2'd1;
   localparam logic [1:0] ST_SLEEP = 2'd2;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;

   localparam logic [31:0] MIE_MASK = 32'h0000_0888;

   logic [1:0]  state_reg, state_next;
   logic [31:0] target_reg, target_next;
   logic        status_mie_reg, status_mie_next;
   logic        status_mpie_reg, status_mpie_next;
   logic [31:0] mie_reg, mie_next;
   logic [29:0] mtvec_base_reg, mtvec_base_next;
   logic [1:0]  mtvec_mode_reg, mtvec_mode_next;
   logic [29:0] mepc_reg, mepc_next;
   logic        mcause_irq_reg, mcause_irq_next;
   logic [3:0]  mcause_code_reg, mcause_code_next;
   logic [31:0] mtval_reg, mtval_next;

   logic [31:0] mip;
   logic [31:0] pending;
   logic [3:0]  irq_code;
   logic [31:0] trap_base;
   logic [31:0] irq_target;
   logic [31:0] wfi_pc_plus4;
   logic        irq_ok;
   logic        mode_legal;
   logic        unused_bits;

   assign mip       = {20'b0, irq_meip_i, 3'b0, irq_mtip_i, 3'b0, irq_msip_i, 3'b0};
   assign pending   = mip & mie_reg;
   assign irq_ok    = status_mie_reg & next_pc_valid_i & (|pending);
   assign trap_base = {mtvec_base_reg, 2'b00};

   // MEI > MSI > MTI
   always_comb begin
      irq_code = 4'd7;
      if (pending[11])
         irq_code = 4'd11;
      else if (pending[3])
         irq_code = 4'd3;
   end

   assign irq_target   = (VECTORED_EN && mtvec_mode_reg == 2'b01) ?
                         trap_base + {26'b0, irq_code, 2'b00} : trap_base;
   assign wfi_pc_plus4 = wfi_pc_i + 32'd4;

   // Reserved or unsupported mode encodings keep the current mode.
   assign mode_legal = (csr_wdata_i[1:0] == 2'b00) ||
                       (VECTORED_EN && csr_wdata_i[1:0] == 2'b01);

   // Low PC bits are never stored in mepc.
   assign unused_bits = ^{exc_pc_i[1:0], next_pc_i[1:0], wfi_pc_plus4[1:0]};

   always_comb begin
      state_next       = state_reg;
      target_next      = target_reg;
      status_mie_next  = status_mie_reg;
      status_mpie_next = status_mpie_reg;
      mie_next         = mie_reg;
      mtvec_base_next  = mtvec_base_reg;
      mtvec_mode_next  = mtvec_mode_reg;
      mepc_next        = mepc_reg;
      mcause_irq_next  = mcause_irq_reg;
      mcause_code_next = mcause_code_reg;
      mtval_next       = mtval_reg;

      // Software writes first; trap-side updates below override the fields
      // they touch and leave the rest of the write in place.
      if (csr_we_i) begin
         case (csr_addr_i)
            CSR_MSTATUS: begin
               status_mie_next  = csr_wdata_i[3];
               status_mpie_next = csr_wdata_i[7];
            end
            CSR_MIE:   mie_next = csr_wdata_i & MIE_MASK;
            CSR_MTVEC: begin
               mtvec_base_next = csr_wdata_i[31:2];
               if (mode_legal)
                  mtvec_mode_next = csr_wdata_i[1:0];
            end
            CSR_MEPC:  mepc_next = csr_wdata_i[31:2];
            CSR_MCAUSE: begin
               mcause_irq_next  = csr_wdata_i[31];
               mcause_code_next = csr_wdata_i[3:0];
            end
            CSR_MTVAL: mtval_next = csr_wdata_i;
            default: ;
         endcase
      end

      case (state_reg)
         ST_IDLE: begin
            if (exc_valid_i) begin
               mepc_next        = exc_pc_i[31:2];
               mcause_irq_next  = 1'b0;
               mcause_code_next = exc_cause_i;
               mtval_next       = exc_tval_i;
               status_mpie_next = status_mie_reg;
               status_mie_next  = 1'b0;
               target_next      = trap_base;
               state_next       = ST_JUMP;
            end else if (irq_ok) begin
               mepc_next        = next_pc_i[31:2];
               mcause_irq_next  = 1'b1;
               mcause_code_next = irq_code;
               mtval_next       = 32'd0;
               status_mpie_next = status_mie_reg;
               status_mie_next  = 1'b0;
               target_next      = irq_target;
               state_next       = ST_JUMP;
            end else if (mret_i) begin
               status_mie_next  = status_mpie_reg;
               status_mpie_next = 1'b1;
               target_next      = {mepc_reg, 2'b00};
               state_next       = ST_JUMP;
            end else if (wfi_i) begin
               state_next = ST_SLEEP;
            end
         end
         ST_JUMP: begin
            if (jump_ack_i)
               state_next = ST_IDLE;
         end
         ST_SLEEP: begin
            // Wake ignores MIE; MIE only decides whether the trap is taken.
            if (|pending) begin
               if (status_mie_reg) begin
                  mepc_next        = wfi_pc_plus4[31:2];
                  mcause_irq_next  = 1'b1;
                  mcause_code_next = irq_code;
                  mtval_next       = 32'd0;
                  status_mpie_next = 1'b1;
                  status_mie_next  = 1'b0;
                  target_next      = irq_target;
                  state_next       = ST_JUMP;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_reg       <= ST_IDLE;
         target_reg      <= 32'd0;
         status_mie_reg  <= 1'b0;
         status_mpie_reg <= 1'b0;
         mie_reg         <= 32'd0;
         mtvec_base_reg  <= MTVEC_RESET[31:2];
         mtvec_mode_reg  <= VECTORED_EN ? MTVEC_RESET[1:0] : 2'b00;
         mepc_reg        <= 30'd0;
         mcause_irq_reg  <= 1'b0;
         mcause_code_reg <= 4'd0;
         mtval_reg       <= 32'd0;
      end else begin
         state_reg       <= state_next;
         target_reg      <= target_next;
         status_mie_reg  <= status_mie_next;
         status_mpie_reg <= status_mpie_next;
         mie_reg         <= mie_next;
         mtvec_base_reg  <= mtvec_base_next;
         mtvec_mode_reg  <= mtvec_mode_next;
         mepc_reg        <= mepc_next;
         mcause_irq_reg  <= mcause_irq_next;
         mcause_code_reg <= mcause_code_next;
         mtval_reg       <= mtval_next;
      end
   end

   assign jump_o      = (state_reg == ST_JUMP);
   assign jump_addr_o = target_reg;
   assign busy_o      = (state_reg != ST_IDLE);
   assign sleep_o     = (state_reg == ST_SLEEP);
   assign mstatus_o   = {24'b0, status_mpie_reg, 3'b0, status_mie_reg, 3'b0};
   assign mie_o       = mie_reg;
   assign mip_o       = mip;
   assign mtvec_o     = {mtvec_base_reg, mtvec_mode_reg};
   assign mepc_o      = {mepc_reg, 2'b00};
   assign mcause_o    = {mcause_irq_reg, 27'b0, mcause_code_reg};
   assign mtval_o     = mtval_reg;

endmodule

// File: tb/tb_jedro_1_trap_ctrl.sv
// tb_jedro_1_trap_ctrl
//   Self-checking bench for jedro_1_trap_ctrl: directed scenarios from the
//   test plan followed by randomized transactions checked against a
//   behavioural model of the trap CSRs.
module tb_jedro_1_trap_ctrl;

   logic        clk_i = 1'b0;
   logic        rstn_i = 1'b1;
   logic        exc_valid_i;
   logic [3:0]  exc_cause_i;
   logic [31:0] exc_pc_i;
   logic [31:0] exc_tval_i;
   logic        mret_i;
   logic        wfi_i;
   logic [31:0] wfi_pc_i;
   logic [31:0] next_pc_i;
   logic        next_pc_valid_i;
   logic        irq_msip_i;
   logic        irq_mtip_i;
   logic        irq_meip_i;
   logic        csr_we_i;
   logic [11:0] csr_addr_i;
   logic [31:0] csr_wdata_i;
   logic        jump_o;
   logic [31:0] jump_addr_o;
   logic        jump_ack_i;
   logic        busy_o;
   logic        sleep_o;
   logic [31:0] mstatus_o, mie_o, mip_o, mtvec_o, mepc_o, mcause_o, mtval_o;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic        m_mie_bit, m_mpie;
   logic [31:0] m_mie, m_mtvec, m_mepc, m_mcause, m_mtval;

   logic [11:0] csr_list [7] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h343, 12'h344};
   logic [3:0]  cause_list [7] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd11};

   jedro_1_trap_ctrl #(
      .MTVEC_RESET (32'h0040_0000),
      .VECTORED_EN (1'b1)
   ) dut (
      .clk_i           (clk_i),
      .rstn_i          (rstn_i),
      .exc_valid_i     (exc_valid_i),
      .exc_cause_i     (exc_cause_i),
      .exc_pc_i        (exc_pc_i),
      .exc_tval_i      (exc_tval_i),
      .mret_i          (mret_i),
      .wfi_i           (wfi_i),
      .wfi_pc_i        (wfi_pc_i),
      .next_pc_i       (next_pc_i),
      .next_pc_valid_i (next_pc_valid_i),
      .irq_msip_i      (irq_msip_i),
      .irq_mtip_i      (irq_mtip_i),
      .irq_meip_i      (irq_meip_i),
      .csr_we_i        (csr_we_i),
      .csr_addr_i      (csr_addr_i),
      .csr_wdata_i     (csr_wdata_i),
      .jump_o          (jump_o),
      .jump_addr_o     (jump_addr_o),
      .jump_ack_i      (jump_ack_i),
      .busy_o          (busy_o),
      .sleep_o         (sleep_o),
      .mstatus_o       (mstatus_o),
      .mie_o           (mie_o),
      .mip_o           (mip_o),
      .mtvec_o         (mtvec_o),
      .mepc_o          (mepc_o),
      .mcause_o        (mcause_o),
      .mtval_o         (mtval_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   // ---------------- model ----------------
   function automatic logic [31:0] model_mstatus();
      return {24'b0, m_mpie, 3'b0, m_mie_bit, 3'b0};
   endfunction

   function automatic logic [191:0] model_csrs();
      return {model_mstatus(), m_mie, m_mtvec, m_mepc, m_mcause, m_mtval};
   endfunction

   function automatic logic [191:0] dut_csrs();
      return {mstatus_o, mie_o, mtvec_o, mepc_o, mcause_o, mtval_o};
   endfunction

   function automatic logic [31:0] model_mip();
      logic [31:0] v;
      v = 32'd0;
      if (irq_msip_i) v = v + 32'd8;
      if (irq_mtip_i) v = v + 32'd128;
      if (irq_meip_i) v = v + 32'd2048;
      return v;
   endfunction

   function automatic int model_code(input logic [31:0] p);
      if (p[11]) return 11;
      if (p[3])  return 3;
      if (p[7])  return 7;
      return -1;
   endfunction

   function automatic logic [31:0] model_irq_target(input int code);
      logic [31:0] base;
      base = m_mtvec & 32'hFFFF_FFFC;
      if (m_mtvec[1:0] == 2'b01)
         return base + 32'(4 * code);
      return base;
   endfunction

   task automatic model_reset();
      m_mie_bit = 1'b0; m_mpie = 1'b0; m_mie = 32'd0;
      m_mtvec = 32'h0040_0000; m_mepc = 32'd0; m_mcause = 32'd0; m_mtval = 32'd0;
   endtask

   task automatic model_csr_write(input logic [11:0] a, input logic [31:0] d);
      case (a)
         12'h300: begin m_mie_bit = d[3]; m_mpie = d[7]; end
         12'h304: m_mie = d & 32'h0000_0888;
         12'h305: begin
            m_mtvec = (m_mtvec & 32'h3) | (d & 32'hFFFF_FFFC);
            if (d[1:0] == 2'b00 || d[1:0] == 2'b01)
               m_mtvec = d;
         end
         12'h341: m_mepc = d & 32'hFFFF_FFFC;
         12'h342: m_mcause = d & 32'h8000_000F;
         12'h343: m_mtval = d;
         default: ;
      endcase
   endtask

   task automatic model_enter(input logic [31:0] epc, input logic [31:0] cause,
                              input logic [31:0] tval, input logic old_mie);
      m_mepc = epc & 32'hFFFF_FFFC;
      m_mcause = cause;
      m_mtval = tval;
      m_mpie = old_mie;
      m_mie_bit = 1'b0;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      exc_valid_i = 0; exc_cause_i = 0; exc_pc_i = 0; exc_tval_i = 0;
      mret_i = 0; wfi_i = 0; wfi_pc_i = 0; next_pc_i = 0; next_pc_valid_i = 0;
      irq_msip_i = 0; irq_mtip_i = 0; irq_meip_i = 0;
      csr_we_i = 0; csr_addr_i = 0; csr_wdata_i = 0; jump_ack_i = 0;
   endtask

   task automatic sw_write(input logic [11:0] a, input logic [31:0] d);
      csr_we_i = 1; csr_addr_i = a; csr_wdata_i = d;
      tick();
      csr_we_i = 0;
      model_csr_write(a, d);
   endtask

   task automatic ack_jump();
      jump_ack_i = 1;
      tick();
      jump_ack_i = 0;
   endtask

   task automatic set_lines(input logic [2:0] l);
      irq_msip_i = l[0]; irq_mtip_i = l[1]; irq_meip_i = l[2];
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      clear_inputs();
      #2 rstn_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      model_reset();
      n_tests++;
      if ({jump_o, busy_o, sleep_o} !== 3'b000) begin
         n_fail++; $display("FAIL reset_ctrl: got %b required 000", {jump_o, busy_o, sleep_o});
      end
      n_tests++;
      if (dut_csrs() !== model_csrs()) begin
         n_fail++; $display("FAIL reset_csrs: got %h required %h", dut_csrs(), model_csrs());
      end
      rstn_i = 1'b1;
      $display("[TB] reset done");
   endtask

   task automatic test_csr_masks();
      sw_write(12'h300, 32'hFFFF_FFFF);
      n_tests++;
      if (mstatus_o !== 32'h0000_0088) begin
         n_fail++; $display("FAIL mstatus_mask: got %h required 00000088", mstatus_o);
      end
      sw_write(12'h304, 32'hFFFF_FFFF);
      n_tests++;
      if (mie_o !== 32'h0000_0888) begin
         n_fail++; $display("FAIL mie_mask: got %h required 00000888", mie_o);
      end
      sw_write(12'h341, 32'h1234_5677);
      n_tests++;
      if (mepc_o !== 32'h1234_5674) begin
         n_fail++; $display("FAIL mepc_mask: got %h required 12345674", mepc_o);
      end
      sw_write(12'h300, 32'h0);
      set_lines(3'b111);
      tick();
      n_tests++;
      if (mip_o !== 32'h0000_0888 || jump_o !== 1'b0) begin
         n_fail++; $display("FAIL mip_lines: got mip %h jump %b required 00000888 0", mip_o, jump_o);
      end
      set_lines(3'b000);
      sw_write(12'h304, 32'h0);
      n_tests++;
      if (dut_csrs() !== model_csrs()) begin
         n_fail++; $display("FAIL masks_csrs: got %h required %h", dut_csrs(), model_csrs());
      end
      $display("[TB] csr masks done");
   endtask

   task automatic test_exception();
      logic [31:0] tgt;
      sw_write(12'h300, 32'h8);
      tgt = m_mtvec & 32'hFFFF_FFFC;
      exc_valid_i = 1; exc_cause_i = 4'd2; exc_pc_i = 32'h8000_0010; exc_tval_i = 32'hFFFF_FFFF;
      tick();
      clear_inputs();
      model_enter(32'h8000_0010, 32'd2, 32'hFFFF_FFFF, 1'b1);
      n_tests++;
      if (dut_csrs() !== model_csrs()) begin
         n_fail++; $display("FAIL exc_csrs: got %h required %h", dut_csrs(), model_csrs());
      end
      n_tests++;
      if ({jump_o, busy_o, sleep_o} !== 3'b110 || jump_addr_o !== 32'h0040_0000) begin
         n_fail++; $display("FAIL exc_jump: got %b %h required 110 00400000", {jump_o, busy_o, sleep_o}, jump_addr_o);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if (jump_o !== 1'b1 || jump_addr_o !== tgt) begin
            n_fail++; $display("FAIL exc_hold: got %b %h required 1 %h", jump_o, jump_addr_o, tgt);
         end
      end
      ack_jump();
      n_tests++;
      if (jump_o !== 1'b0 || busy_o !== 1'b0) begin
         n_fail++; $display("FAIL exc_ack: got %b %b required 0 0", jump_o, busy_o);
      end
      $display("[TB] exception done");
   endtask

   task automatic test_irq_priority();
      logic [31:0] tgt;
      sw_write(12'h304, 32'h888);
      sw_write(12'h305, 32'h0040_0001);
      sw_write(12'h300, 32'h8);
      set_lines(3'b111);
      next_pc_i = 32'h8000_0100; next_pc_valid_i = 1;
      tgt = model_irq_target(model_code(model_mip() & m_mie));
      tick();
      n_tests++;
      if (mip_o !== 32'h888) begin
         n_fail++; $display("FAIL irq_mip: got %h required 00000888", mip_o);
      end
      clear_inputs();
      model_enter(32'h8000_0100, 32'h8000_000B, 32'd0, 1'b1);
      n_tests++;
      if (dut_csrs() !== model_csrs()) begin
         n_fail++; $display("FAIL irq_csrs: got %h required %h", dut_csrs(), model_csrs());
      end
      n_tests++;
      if (jump_o !== 1'b1 || jump_addr_o !== tgt || tgt !== 32'h0040_002C) begin
         n_fail++; $display("FAIL irq_vector: got %b %h required 1 0040002c", jump_o, jump_addr_o);
      end
      ack_jump();
      $display("[TB] irq priority done");
   endtask

   task automatic test_exc_vs_irq();
      sw_write(12'h300, 32'h8);
      irq_mtip_i = 1; next_pc_i = 32'h8000_0480; next_pc_valid_i = 1;
      exc_valid_i = 1; exc_cause_i = 4'd11; exc_pc_i = 32'h8000_0400; exc_tval_i = 32'd0;
      tick();
      exc_valid_i = 0;
      model_enter(32'h8000_0400, 32'd11, 32'd0, 1'b1);
      n_tests++;
      if (dut_csrs() !== model_csrs() || jump_addr_o !== 32'h0040_0000) begin
         n_fail++; $display("FAIL exc_wins: got %h %h required %h 00400000", dut_csrs(), jump_addr_o, model_csrs());
      end
      ack_jump();
      tick();
      n_tests++;
      if (jump_o !== 1'b0) begin
         n_fail++; $display("FAIL irq_masked: got jump %b required 0", jump_o);
      end
      mret_i = 1;
      tick();
      mret_i = 0;
      m_mie_bit = m_mpie; m_mpie = 1'b1;
      n_tests++;
      if (jump_addr_o !== 32'h8000_0400 || mstatus_o !== 32'h88) begin
         n_fail++; $display("FAIL exc_mret: got %h %h required 80000400 00000088", jump_addr_o, mstatus_o);
      end
      ack_jump();
      n_tests++;
      if (jump_o !== 1'b0) begin
         n_fail++; $display("FAIL mret_ack: got jump %b required 0", jump_o);
      end
      tick();
      model_enter(32'h8000_0480, 32'h8000_0007, 32'd0, 1'b1);
      n_tests++;
      if (jump_o !== 1'b1 || dut_csrs() !== model_csrs() || jump_addr_o !== model_irq_target(7)) begin
         n_fail++; $display("FAIL irq_after_mret: got %b %h %h required 1 %h %h", jump_o, dut_csrs(), jump_addr_o, model_csrs(), model_irq_target(7));
      end
      clear_inputs();
      ack_jump();
      $display("[TB] exc vs irq done");
   endtask

   task automatic test_mret();
      sw_write(12'h341, 32'h8000_0204);
      sw_write(12'h300, 32'h80);
      mret_i = 1;
      tick();
      mret_i = 0;
      m_mie_bit = m_mpie; m_mpie = 1'b1;
      n_tests++;
      if (mstatus_o !== 32'h88 || jump_o !== 1'b1 || jump_addr_o !== 32'h8000_0204) begin
         n_fail++; $display("FAIL mret: got %h %b %h required 00000088 1 80000204", mstatus_o, jump_o, jump_addr_o);
      end
      ack_jump();
      $display("[TB] mret done");
   endtask

   task automatic test_wfi();
      sw_write(12'h300, 32'h0);
      sw_write(12'h304, 32'h80);
      wfi_i = 1; wfi_pc_i = 32'h8000_0300;
      tick();
      wfi_i = 0;
      repeat (3) tick();
      n_tests++;
      if ({jump_o, busy_o, sleep_o} !== 3'b011) begin
         n_fail++; $display("FAIL wfi_sleep: got %b required 011", {jump_o, busy_o, sleep_o});
      end
      irq_mtip_i = 1;
      tick();
      n_tests++;
      if ({jump_o, busy_o, sleep_o} !== 3'b000 || dut_csrs() !== model_csrs()) begin
         n_fail++; $display("FAIL wfi_wake_nojump: got %b %h required 000 %h", {jump_o, busy_o, sleep_o}, dut_csrs(), model_csrs());
      end
      irq_mtip_i = 0;
      tick();
      sw_write(12'h300, 32'h8);
      wfi_i = 1; wfi_pc_i = 32'h8000_0300;
      tick();
      wfi_i = 0;
      n_tests++;
      if (sleep_o !== 1'b1) begin
         n_fail++; $display("FAIL wfi_sleep2: got %b required 1", sleep_o);
      end
      irq_mtip_i = 1;
      tick();
      model_enter(32'h8000_0304, 32'h8000_0007, 32'd0, 1'b1);
      n_tests++;
      if (dut_csrs() !== model_csrs() || jump_o !== 1'b1 || jump_addr_o !== model_irq_target(7) || sleep_o !== 1'b0) begin
         n_fail++; $display("FAIL wfi_wake_trap: got %h %b %h required %h 1 %h", dut_csrs(), jump_o, jump_addr_o, model_csrs(), model_irq_target(7));
      end
      clear_inputs();
      ack_jump();
      $display("[TB] wfi done");
   endtask

   task automatic test_reset_mid_jump();
      exc_valid_i = 1; exc_cause_i = 4'd5; exc_pc_i = 32'h8000_0500; exc_tval_i = 32'h55;
      tick();
      clear_inputs();
      n_tests++;
      if (jump_o !== 1'b1) begin
         n_fail++; $display("FAIL rst_pre_jump: got %b required 1", jump_o);
      end
      #2 rstn_i = 1'b0;
      #1;
      model_reset();
      n_tests++;
      if ({jump_o, busy_o, sleep_o} !== 3'b000 || dut_csrs() !== model_csrs()) begin
         n_fail++; $display("FAIL rst_async: got %b %h required 000 %h", {jump_o, busy_o, sleep_o}, dut_csrs(), model_csrs());
      end
      tick();
      rstn_i = 1'b1;
      sw_write(12'h305, 32'h0050_0002);
      n_tests++;
      if (mtvec_o !== 32'h0050_0000) begin
         n_fail++; $display("FAIL mtvec_mode10: got %h required 00500000", mtvec_o);
      end
      sw_write(12'h305, 32'h0060_0003);
      n_tests++;
      if (mtvec_o !== 32'h0060_0000) begin
         n_fail++; $display("FAIL mtvec_mode11: got %h required 00600000", mtvec_o);
      end
      sw_write(12'h305, 32'h0070_0001);
      n_tests++;
      if (mtvec_o !== 32'h0070_0001) begin
         n_fail++; $display("FAIL mtvec_mode01: got %h required 00700001", mtvec_o);
      end
      $display("[TB] reset mid jump done");
   endtask

   task automatic test_random(input int n);
      logic [31:0] r, d, pc, tval, tgt, npc, pend;
      logic [11:0] a;
      logic [3:0]  cause;
      logic [2:0]  lines;
      logic        w, valid, take, old_mie;
      int          op, code, delay;
      r = $urandom;
      sw_write(12'h305, {r[31:2], 2'b01});
      for (int it = 0; it < n; it++) begin
         op = int'($urandom_range(0, 4));
         case (op)
            0: begin
               a = csr_list[$urandom_range(0, 6)];
               d = $urandom;
               sw_write(a, d);
               n_tests++;
               if (dut_csrs() !== model_csrs()) begin
                  n_fail++; $display("FAIL rand_write: got %h required %h", dut_csrs(), model_csrs());
               end
            end
            1: begin
               cause = cause_list[$urandom_range(0, 6)];
               pc = $urandom; tval = $urandom;
               tgt = m_mtvec & 32'hFFFF_FFFC;
               old_mie = m_mie_bit;
               exc_valid_i = 1; exc_cause_i = cause; exc_pc_i = pc; exc_tval_i = tval;
               mret_i = 1'($urandom_range(0, 1)); wfi_i = 1'($urandom_range(0, 1));
               set_lines(3'($urandom_range(0, 7)));
               next_pc_i = $urandom; next_pc_valid_i = 1'($urandom_range(0, 1));
               w = 1'($urandom_range(0, 1));
               a = csr_list[$urandom_range(0, 6)];
               d = $urandom;
               if (w) begin
                  csr_we_i = 1; csr_addr_i = a; csr_wdata_i = d;
               end
               tick();
               clear_inputs();
               if (w) model_csr_write(a, d);
               model_enter(pc, {28'b0, cause}, tval, old_mie);
               n_tests++;
               if (dut_csrs() !== model_csrs() || jump_o !== 1'b1 || jump_addr_o !== tgt) begin
                  n_fail++; $display("FAIL rand_exc: got %h %b %h required %h 1 %h", dut_csrs(), jump_o, jump_addr_o, model_csrs(), tgt);
               end
               delay = int'($urandom_range(0, 3));
               for (int k = 0; k < delay; k++) begin
                  tick();
                  n_tests++;
                  if (jump_o !== 1'b1 || jump_addr_o !== tgt) begin
                     n_fail++; $display("FAIL rand_hold: got %b %h required 1 %h", jump_o, jump_addr_o, tgt);
                  end
               end
               ack_jump();
               n_tests++;
               if (jump_o !== 1'b0) begin
                  n_fail++; $display("FAIL rand_ack: got %b required 0", jump_o);
               end
            end
            2: begin
               if (!m_mie_bit && $urandom_range(0, 1) == 1)
                  sw_write(12'h300, {24'b0, m_mpie, 3'b0, 1'b1, 3'b0});
               if (m_mie == 32'd0)
                  sw_write(12'h304, $urandom);
               lines = 3'($urandom_range(0, 7));
               set_lines(lines);
               npc = $urandom; valid = 1'($urandom_range(0, 1));
               next_pc_i = npc; next_pc_valid_i = valid;
               pend = model_mip() & m_mie;
               take = m_mie_bit && valid && (pend != 32'd0);
               code = model_code(pend);
               tgt = model_irq_target(code);
               tick();
               clear_inputs();
               if (take) begin
                  model_enter(npc, 32'h8000_0000 | 32'(code), 32'd0, 1'b1);
                  n_tests++;
                  if (dut_csrs() !== model_csrs() || jump_o !== 1'b1 || jump_addr_o !== tgt) begin
                     n_fail++; $display("FAIL rand_irq: got %h %b %h required %h 1 %h", dut_csrs(), jump_o, jump_addr_o, model_csrs(), tgt);
                  end
                  ack_jump();
               end else begin
                  n_tests++;
                  if ({jump_o, busy_o, sleep_o} !== 3'b000 || dut_csrs() !== model_csrs()) begin
                     n_fail++; $display("FAIL rand_noirq: got %b %h required 000 %h", {jump_o, busy_o, sleep_o}, dut_csrs(), model_csrs());
                  end
               end
            end
            3: begin
               tgt = m_mepc;
               mret_i = 1;
               tick();
               clear_inputs();
               m_mie_bit = m_mpie; m_mpie = 1'b1;
               n_tests++;
               if (dut_csrs() !== model_csrs() || jump_o !== 1'b1 || jump_addr_o !== tgt) begin
                  n_fail++; $display("FAIL rand_mret: got %h %b %h required %h 1 %h", dut_csrs(), jump_o, jump_addr_o, model_csrs(), tgt);
               end
               ack_jump();
            end
            default: begin
               if (m_mie == 32'd0)
                  sw_write(12'h304, 32'h888);
               pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
               wfi_i = 1; wfi_pc_i = pc;
               tick();
               wfi_i = 0;
               n_tests++;
               if ({jump_o, busy_o, sleep_o} !== 3'b011) begin
                  n_fail++; $display("FAIL rand_sleep: got %b required 011", {jump_o, busy_o, sleep_o});
               end
               repeat ($urandom_range(0, 2)) tick();
               lines = 3'($urandom_range(1, 7));
               set_lines(lines);
               for (int k = 0; k < 32 && ((model_mip() & m_mie) == 32'd0); k++) begin
                  lines = 3'($urandom_range(1, 7));
                  set_lines(lines);
               end
               if ((model_mip() & m_mie) == 32'd0)
                  set_lines(3'b111);
               pend = model_mip() & m_mie;
               code = model_code(pend);
               tgt = model_irq_target(code);
               take = m_mie_bit;
               tick();
               clear_inputs();
               if (take) begin
                  model_enter(pc + 32'd4, 32'h8000_0000 | 32'(code), 32'd0, 1'b1);
                  n_tests++;
                  if (dut_csrs() !== model_csrs() || jump_o !== 1'b1 || jump_addr_o !== tgt) begin
                     n_fail++; $display("FAIL rand_wake_trap: got %h %b %h required %h 1 %h", dut_csrs(), jump_o, jump_addr_o, model_csrs(), tgt);
                  end
                  ack_jump();
               end else begin
                  n_tests++;
                  if ({jump_o, busy_o, sleep_o} !== 3'b000 || dut_csrs() !== model_csrs()) begin
                     n_fail++; $display("FAIL rand_wake_idle: got %b %h required 000 %h", {jump_o, busy_o, sleep_o}, dut_csrs(), model_csrs());
                  end
               end
            end
         endcase
         $display("[TB] rand %0d op %0d", it, op);
      end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_csr_masks();
      test_exception();
      test_irq_priority();
      test_exc_vs_irq();
      test_mret();
      test_wfi();
      test_reset_mid_jump();
      test_random(80);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/jedro_1_trap_ctrl.md
Name: jedro_1_trap_ctrl

Overview:
- Trap sequencer for the jedro_1 core.
- Arbitrates synchronous exceptions, machine interrupts (MEI/MSI/MTI), MRET and WFI.
- Owns the trap CSRs: mstatus.MIE/MPIE, mie, mtvec, mepc, mcause, mtval.
- Redirects fetch through a jump handshake and stalls the pipeline while a trap is being sequenced. Sits beside decode/LSU and feeds the fetch unit and the CSR read mux.

Parameters:
MTVEC_RESET, 32'h0040_0000, reset value of mtvec (base 30'h0010_0000, mode 00 direct).
VECTORED_EN, 1, 1 = mtvec mode 01 (vectored) is supported; 0 = mode field is hardwired to 00.

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
exc_valid_i  in  1  exception request from decode/LSU
exc_cause_i  in  4  exception code (0,2,3,4,5,6,11)
exc_pc_i  in  32  PC of the faulting instruction
exc_tval_i  in  32  trap value (bad address / instruction bits / 0)
mret_i  in  1  MRET retiring
wfi_i  in  1  WFI retiring
wfi_pc_i  in  32  PC of the WFI instruction
next_pc_i  in  32  PC of the next instruction to issue (interrupt mepc)
next_pc_valid_i  in  1  next_pc_i is precise; an interrupt may be taken
irq_msip_i, irq_mtip_i, irq_meip_i  in  1 each  interrupt pending lines (level)
csr_we_i  in  1  software CSR write strobe (already resolved RW/RS/RC value)
csr_addr_i  in  12  CSR address
csr_wdata_i  in  32  CSR write data
jump_o  out  1  redirect request to fetch
jump_addr_o  out  32  redirect target
jump_ack_i  in  1  fetch accepted the redirect
busy_o  out  1  stall decode/issue
sleep_o  out  1  core in WFI sleep
mstatus_o, mie_o, mip_o, mtvec_o, mepc_o, mcause_o, mtval_o  out  32 each  CSR read values

Behaviour:
- Reset (async, rstn_i=0): state IDLE, jump_o=0, busy_o=0, sleep_o=0, MIE=MPIE=0, mie=0, mtvec=MTVEC_RESET, mepc=mcause=mtval=0. Reset mid-sequence aborts immediately; no partial CSR update survives.
- mstatus_o: only bit 3 (MIE) and bit 7 (MPIE) are live; all other bits read 0.
- mip_o: combinational from the irq inputs at bits 3/7/11.
- mie_o: only bits 3/7/11 are writable; all other bits read 0.
- mepc: bits [1:0] always 0.
- States: IDLE, JUMP, SLEEP.
- IDLE: evaluate in this priority order; only one event is accepted per cycle.
  1. exc_valid_i: at the next edge mepc<=exc_pc_i, mcause<={28'b0,exc_cause_i}, mtval<=exc_tval_i, MPIE<=MIE, MIE<=0; target=mtvec base; go to JUMP.
  2. Interrupt: requires MIE=1, next_pc_valid_i=1 and (mip&mie)!=0.
     - Priority MEI(11) > MSI(3) > MTI(7).
     - mepc<=next_pc_i, mcause<={1'b1,27'b0,code}, mtval<=0, MPIE<=MIE, MIE<=0.
     - target = base, or base+4*code when VECTORED_EN=1 and mode=01.
     - Go to JUMP.
  3. mret_i: MIE<=MPIE, MPIE<=1; target=mepc; go to JUMP.
  4. wfi_i: go to SLEEP.
- JUMP: jump_o=1, jump_addr_o=target held stable, busy_o=1. On jump_ack_i go to IDLE (jump_o drops the next cycle). New requests are ignored while not IDLE.
- Latency: event sampled at edge N; CSRs updated and jump_o=1 from cycle N+1; minimum one cycle in JUMP.
- SLEEP: sleep_o=1, busy_o=1. Wake when (mip&mie)!=0, regardless of MIE.
  - Wake with MIE=1: take the interrupt with mepc<=wfi_pc_i+4 and go to JUMP.
  - Wake with MIE=0: go to IDLE; issue resumes in order and no jump is issued.
- Software CSR writes apply in any state. If a write hits the same edge as a trap, MRET or wake update, the trap-side update wins for overlapping registers/fields and the other fields of the write still apply.
- mtvec writes: a mode value of 1x, or 01 when VECTORED_EN=0, keeps the old mode and still writes the base.
- Writes to mcause, mtval and mstatus outside the live bits are masked.
- Arithmetic: target and mepc arithmetic is 32-bit and wraps modulo 2^32.

Test Plan:
- Illegal instr: exc_valid_i=1, cause=2, pc=0x8000_0010, tval=0xFFFF_FFFF, MIE=1 -> next cycle mepc=0x8000_0010, mcause=2, mtval=0xFFFF_FFFF, MIE=0, MPIE=1, jump_o=1, addr=0x0040_0000 held until jump_ack_i (test ack delayed 3 cycles).
- Interrupt priority: mie=0x888, MIE=1, all three irq lines high, next_pc=0x8000_0100, mtvec=0x0040_0001 -> mcause=0x8000_000B, mepc=0x8000_0100, jump_addr=0x0040_002C.
- Exception and interrupt in the same cycle -> exception taken (mcause=exception code); the interrupt is taken after MRET re-enables MIE.
- MRET with MPIE=1, mepc=0x8000_0204 -> MIE=1, MPIE=1, jump_addr=0x8000_0204.
- WFI at 0x8000_0300 with MIE=0, mie.MTIE=1: sleep_o=1 until irq_mtip_i rises, then IDLE, no jump. Repeat with MIE=1 -> mepc=0x8000_0304, mcause=0x8000_0007.
- Reset asserted during JUMP -> jump_o, busy_o and all CSRs return to reset values asynchronously; an mtvec write of mode 2'b10 leaves the mode at 00.
